branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//  Next-PC generator that sits directly upstream of the PC register and drives its pc_i.
//  It holds a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
//  Each cycle it predicts the next fetch PC from the current fetch PC.
//  A mispredict redirect from EX overrides the prediction. EX branch outcomes train the table.
//  Two saturating performance counters are kept for branches resolved and mispredicts.
// PARAMETERS
//  ENTRIES   16  number of BTB entries; power of 2, >= 2
//  IDX_W     4   log2(ENTRIES); index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]
// PORTS
//  clk_i            in   1   clock, rising edge
//  rst_i            in   1   asynchronous active-low reset
//  start_i          in   1   CPU run enable; when 0, no table or counter update
//  MemStall_i       in   1   data-cache stall; pipeline frozen, no update this cycle
//  fetch_pc_i       in   32  current fetch PC (PC register output)
//  upd_valid_i      in   1   EX stage holds a resolved conditional branch
//  upd_pc_i         in   32  PC of that branch
//  upd_taken_i      in   1   actual outcome
//  upd_target_i     in   32  actual taken target
//  redirect_i       in   1   EX detected mispredict; forces next PC
//  redirect_pc_i    in   32  correct next PC on mispredict
//  next_pc_o        out  32  next fetch PC, to PC pc_i (combinational)
//  pred_taken_o     out  1   prediction for fetch_pc_i; piped down with the instruction
//  branch_cnt_o     out  32  resolved branches, saturating at 32'hFFFF_FFFF
//  mispred_cnt_o    out  32  redirects taken, saturating at 32'hFFFF_FFFF
// BEHAVIOUR
//  Storage per entry: valid (1), tag (32-IDX_W-2), target (32), ctr (2).
//  Reset (async, rst_i=0): all valid=0, all ctr=2'b01, both perf counters = 0.
//   Outputs then read next_pc_o = fetch_pc_i+4 and pred_taken_o = 0.
//  Lookup (combinational, zero latency):
//   hit = valid[idx] & tag match. pred_taken_o = hit & ctr[1].
//  next_pc_o priority: redirect_i ? redirect_pc_i : pred_taken_o ? target[idx] : fetch_pc_i+4.
//   PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
//  Update enable: upd_en = upd_valid_i & start_i & ~MemStall_i. It is sampled at posedge clk_i.
//   The MemStall_i gate prevents double training while EX is frozen.
//  On upd_en, the table entry idx is derived from upd_pc_i.
//   Hit, taken: ctr = sat_inc(ctr), target <= upd_target_i.
//   Hit, not taken: ctr = sat_dec(ctr). Counters saturate at 2'b11 and 2'b00.
//   Miss, taken: allocate/overwrite with valid=1, new tag, target=upd_target_i, ctr=2'b10.
//   Miss, not taken: no table change.
//  Perf counters:
//   branch_cnt_o += 1 on upd_en.
//   mispred_cnt_o += 1 on redirect_i & start_i & ~MemStall_i.
//   Both counters saturate and never wrap.
//  Same-cycle lookup and update to the same index: no bypass; lookup sees pre-edge contents.
//   The new contents are visible the cycle after the edge.
//  redirect_i without upd_valid_i (e.g. a jump): steer only; no table change.
//  A reset asserted mid-operation immediately clears the state above, regardless of clk_i.
//   Operation resumes on the first edge after rst_i=1.
//  start_i=0: lookups and redirects still drive next_pc_o; state is frozen.
// TESTING
//  1 Reset, then fetch_pc_i=0x100, no update -> next_pc_o=0x104, pred_taken_o=0, counters=0.
//  2 Train 0x40 taken->0x20 with two upd_en cycles -> ctr 10 then 11.
//    Then fetch_pc_i=0x40 -> next_pc_o=0x20, pred_taken_o=1, branch_cnt_o=2.
//  3 Three not-taken updates on 0x40 -> ctr 11->10->01->00; fetch 0x40 -> next_pc_o=0x44.
//  4 Alias: 0x40 is trained taken; with ENTRIES=16, fetch 0x440 (same idx, tag differs).
//    -> miss, next_pc_o=0x444. Taken update at 0x440 replaces the entry, and 0x40 now misses.
//  5 Hold upd_valid_i=1 with MemStall_i=1 for 5 cycles, then 1 cycle with MemStall_i=0.
//    -> ctr moves exactly one step, branch_cnt_o += 1.
//  6 redirect_i=1 with redirect_pc_i=0x200 while fetch hits taken ->0x20 -> next_pc_o=0x200.
//    mispred_cnt_o += 1. Then drop rst_i mid-cycle -> table invalid and counters 0 without a clock edge.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Next-PC generator: direct-mapped BTB with 2-bit counters,
// EX redirect override and saturating branch/mispredict counters.
module branch_predict_unit #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        MemStall_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] next_pc_o,
    output logic        pred_taken_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             upd_en;
    logic             mis_en;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_d;

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{fetch_pc_i[1:0], upd_pc_i[1:0]};

    // Lookup path: sees pre-edge table contents, no bypass.
    assign f_idx = fetch_pc_i[IDX_W+1:2];
    assign f_tag = fetch_pc_i[31:IDX_W+2];
    assign f_hit = valid_q[f_idx] & (tag_q[f_idx] == f_tag);

    assign pred_taken_o = f_hit & ctr_q[f_idx][1];

    always_comb begin
        next_pc_o = fetch_pc_i + 32'd4;
        if (redirect_i) begin
            next_pc_o = redirect_pc_i;
        end else if (pred_taken_o) begin
            next_pc_o = tgt_q[f_idx];
        end
    end

    // Training path: frozen while the CPU is idle or EX is stalled.
    assign upd_en = upd_valid_i & start_i & ~MemStall_i;
    assign mis_en = redirect_i & start_i & ~MemStall_i;

    assign u_idx   = upd_pc_i[IDX_W+1:2];
    assign u_tag   = upd_pc_i[31:IDX_W+2];
    assign u_hit   = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
    assign ctr_cur = ctr_q[u_idx];

    always_comb begin
        ctr_d = ctr_cur;
        if (upd_taken_i) begin
            if (ctr_cur != 2'b11) begin
                ctr_d = ctr_cur + 2'd1;
            end
        end else begin
            if (ctr_cur != 2'b00) begin
                ctr_d = ctr_cur - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else if (upd_en) begin
            if (u_hit) begin
                ctr_q[u_idx] <= ctr_d;
                if (upd_taken_i) begin
                    tgt_q[u_idx] <= upd_target_i;
                end
            end else if (upd_taken_i) begin
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= u_tag;
                tgt_q[u_idx]   <= upd_target_i;
                ctr_q[u_idx]   <= 2'b10;
            end
        end
    end

    // Perf counters stick at all-ones instead of wrapping.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_en && (branch_cnt_q != 32'hFFFF_FFFF)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (mis_en && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: lookup, training,
// aliasing, stall gating, redirect and asynchronous reset.
module tb_branch_predict_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        MemStall_i;
    logic [31:0] fetch_pc_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] next_pc_o;
    logic        pred_taken_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    int n_vec = 0;
    int n_bad = 0;

    branch_predict_unit #(.ENTRIES(16), .IDX_W(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .MemStall_i    (MemStall_i),
        .fetch_pc_i    (fetch_pc_i),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_taken_i   (upd_taken_i),
        .upd_target_i  (upd_target_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .next_pc_o     (next_pc_o),
        .pred_taken_o  (pred_taken_o),
        .branch_cnt_o  (branch_cnt_o),
        .mispred_cnt_o (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic upd(input logic v, input logic [31:0] pc,
                       input logic tk, input logic [31:0] tgt);
        upd_valid_i  = v;
        upd_pc_i     = pc;
        upd_taken_i  = tk;
        upd_target_i = tgt;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic [31:0] exp_npc, input logic exp_pt);
        fetch_pc_i = pc;
        #1;
        chk({tag, "_npc"}, next_pc_o, exp_npc);
        chk({tag, "_pt"}, {31'd0, pred_taken_o}, {31'd0, exp_pt});
    endtask

    initial begin
        rst_i         = 1'b0;
        start_i       = 1'b1;
        MemStall_i    = 1'b0;
        fetch_pc_i    = 32'h100;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        upd(1'b0, 32'h0, 1'b0, 32'h0);

        // 1: reset state
        #12;
        look("rst", 32'h100, 32'h104, 1'b0);
        chk("rst_bcnt", branch_cnt_o, 32'd0);
        chk("rst_mcnt", mispred_cnt_o, 32'd0);
        look("wrap", 32'hFFFF_FFFC, 32'h0, 1'b0);
        rst_i = 1'b1;
        tick();

        // 2: allocate then strengthen 0x40 -> 0x20
        upd(1'b1, 32'h40, 1'b1, 32'h20);
        look("pre_alloc", 32'h40, 32'h44, 1'b0);
        tick();
        look("alloc", 32'h40, 32'h20, 1'b1);
        chk("alloc_bcnt", branch_cnt_o, 32'd1);
        tick();
        upd(1'b0, 32'h40, 1'b0, 32'h0);
        look("strong", 32'h40, 32'h20, 1'b1);
        chk("strong_bcnt", branch_cnt_o, 32'd2);

        // 3: decay 11->10->01->00
        upd(1'b1, 32'h40, 1'b0, 32'h0);
        tick();
        look("dec1", 32'h40, 32'h20, 1'b1);
        tick();
        look("dec2", 32'h40, 32'h44, 1'b0);
        tick();
        look("dec3", 32'h40, 32'h44, 1'b0);
        chk("dec_bcnt", branch_cnt_o, 32'd5);
        // 00 needs two taken steps to predict taken again
        upd(1'b1, 32'h40, 1'b1, 32'h20);
        tick();
        look("inc1", 32'h40, 32'h44, 1'b0);
        tick();
        upd(1'b0, 32'h40, 1'b0, 32'h0);
        look("inc2", 32'h40, 32'h20, 1'b1);
        chk("inc_bcnt", branch_cnt_o, 32'd7);

        // 4: alias 0x440 shares index 0 with 0x40
        look("alias_miss", 32'h440, 32'h444, 1'b0);
        upd(1'b1, 32'h440, 1'b1, 32'h300);
        tick();
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        look("alias_new", 32'h440, 32'h300, 1'b1);
        look("alias_old", 32'h40, 32'h44, 1'b0);
        chk("alias_bcnt", branch_cnt_o, 32'd8);

        // 5: stall holds state; one unstalled cycle steps once
        MemStall_i = 1'b1;
        upd(1'b1, 32'h440, 1'b0, 32'h0);
        repeat (5) tick();
        look("stall", 32'h440, 32'h300, 1'b1);
        chk("stall_bcnt", branch_cnt_o, 32'd8);
        MemStall_i = 1'b0;
        tick();
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        look("unstall", 32'h440, 32'h444, 1'b0);
        chk("unstall_bcnt", branch_cnt_o, 32'd9);
        upd(1'b1, 32'h440, 1'b1, 32'h300);
        tick();
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        look("one_step", 32'h440, 32'h300, 1'b1);
        chk("one_step_bcnt", branch_cnt_o, 32'd10);

        // start_i=0 freezes table and counters
        start_i = 1'b0;
        upd(1'b1, 32'h440, 1'b0, 32'h0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h500;
        tick();
        look("idle_redir", 32'h440, 32'h500, 1'b1);
        redirect_i = 1'b0;
        upd(1'b0, 32'h0, 1'b0, 32'h0);
        start_i = 1'b1;
        look("idle_tbl", 32'h440, 32'h300, 1'b1);
        chk("idle_bcnt", branch_cnt_o, 32'd10);
        chk("idle_mcnt", mispred_cnt_o, 32'd0);

        // 6: redirect overrides a taken hit, no table change
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        look("redir", 32'h440, 32'h200, 1'b1);
        tick();
        redirect_i = 1'b0;
        look("post_redir", 32'h440, 32'h300, 1'b1);
        chk("redir_mcnt", mispred_cnt_o, 32'd1);
        chk("redir_bcnt", branch_cnt_o, 32'd10);

        // asynchronous reset mid-cycle
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        look("arst", 32'h440, 32'h444, 1'b0);
        chk("arst_bcnt", branch_cnt_o, 32'd0);
        chk("arst_mcnt", mispred_cnt_o, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
